// File: rtl/gactx_bank3_pkg.sv
// Shared constants and types for the bank-3 AXI4-Stream to AXI4 write master.
package gactx_bank3_pkg;

    localparam int BPB      = 64;
    localparam int LOG2_BPB = 6;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_BPB   = 3'(LOG2_BPB);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_WAIT_B = 2'd2,
        ST_DONE   = 2'd3
    } wr_state_e;

endpackage

// File: rtl/gactx_bank3_xfer_counter.sv
// Loadable down-counter; saturates at zero and flags zero/one remaining.
module gactx_bank3_xfer_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         decr,
    output logic [W-1:0] count,
    output logic         done,
    output logic         last
);

    logic [W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (decr && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = (count_q == '0);
    assign last  = (count_q == W'(1));

endmodule

// File: rtl/gactx_bank3_axis_wr_master.sv
// Writes a 512-bit AXI4-Stream to memory as INCR bursts; one transfer per ctrl_start,
// ctrl_done pulses once every burst has been B-acknowledged.
module gactx_bank3_axis_wr_master
    import gactx_bank3_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_BURST_LEN        = 64,
    parameter int C_MAX_OUTSTANDING  = 16
) (
    input  logic                            aclk,
    input  logic                            areset_n,
    input  logic                            ctrl_start,
    output logic                            ctrl_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_xfer_size_in_bytes,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wlast,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axis_tdata,
    output wr_state_e                       dbg_state
);

    localparam int AW      = C_M_AXI_ADDR_WIDTH;
    localparam int XW      = C_XFER_SIZE_WIDTH;
    localparam int BL_LOG2 = $clog2(C_BURST_LEN);
    localparam int OW      = $clog2(C_MAX_OUTSTANDING + 1);
    localparam logic [AW-1:0] BURST_BYTES = AW'(C_BURST_LEN * BPB);

    wr_state_e        state_d, state_q;
    logic             ctrl_done_d, ctrl_done_q;
    logic             bready_q;
    logic             awvalid_d, awvalid_q;
    logic [AW-1:0]    awaddr_d, awaddr_q;
    logic [7:0]       awlen_d, awlen_q;
    logic [AW-1:0]    next_addr_d, next_addr_q;
    logic [7:0]       last_awlen_d, last_awlen_q;
    logic [OW-1:0]    outstanding_d, outstanding_q;
    logic [OW-1:0]    w_credit_d, w_credit_q;
    logic [BL_LOG2-1:0] w_beat_d, w_beat_q;

    logic [XW-1:0]    beats_in, bursts_in;
    logic [BL_LOG2-1:0] rem_in;
    logic             start_ok;
    logic             aw_hs, w_hs, b_hs, w_ok, wlast, aw_issue;

    logic [XW-1:0]    aw_left, w_left, b_left;
    logic             aw_left_done, aw_left_last;
    logic             w_left_done, w_left_last;
    logic             b_left_done, b_left_last;

    assign beats_in  = ctrl_xfer_size_in_bytes >> LOG2_BPB;
    assign rem_in    = beats_in[BL_LOG2-1:0];
    assign bursts_in = (beats_in >> BL_LOG2) + XW'(rem_in != '0);
    assign start_ok  = (state_q == ST_IDLE) && ctrl_start;

    // A W beat may only flow for a burst whose AW handshake already completed.
    assign w_ok  = (state_q == ST_RUN) && (w_credit_q != '0);
    assign w_hs  = s_axis_tvalid && m_axi_wready && w_ok;
    assign aw_hs = awvalid_q && m_axi_awready;
    assign b_hs  = m_axi_bvalid && bready_q &&
                   ((state_q == ST_RUN) || (state_q == ST_WAIT_B));
    assign wlast = (w_beat_q == BL_LOG2'(C_BURST_LEN - 1)) || w_left_last;

    gactx_bank3_xfer_counter #(.W(XW)) u_aw_cnt (
        .clk(aclk), .rst_n(areset_n), .load(start_ok), .load_value(bursts_in),
        .decr(aw_hs), .count(aw_left), .done(aw_left_done), .last(aw_left_last)
    );

    gactx_bank3_xfer_counter #(.W(XW)) u_w_cnt (
        .clk(aclk), .rst_n(areset_n), .load(start_ok), .load_value(beats_in),
        .decr(w_hs), .count(w_left), .done(w_left_done), .last(w_left_last)
    );

    gactx_bank3_xfer_counter #(.W(XW)) u_b_cnt (
        .clk(aclk), .rst_n(areset_n), .load(start_ok), .load_value(bursts_in),
        .decr(b_hs), .count(b_left), .done(b_left_done), .last(b_left_last)
    );

    // Transitions look one handshake ahead so ctrl_done follows the final B by one cycle.
    always_comb begin
        state_d     = state_q;
        ctrl_done_d = (state_q == ST_DONE);
        unique case (state_q)
            ST_IDLE:   if (ctrl_start) state_d = (beats_in == '0) ? ST_DONE : ST_RUN;
            ST_RUN:    if (aw_left_done && (w_left_done || (w_left_last && w_hs)))
                           state_d = ST_WAIT_B;
            ST_WAIT_B: if (b_left_done || (b_left_last && b_hs)) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign aw_issue = (state_q == ST_RUN) && !awvalid_q && !aw_left_done &&
                      (outstanding_q < OW'(C_MAX_OUTSTANDING));

    always_comb begin
        awvalid_d    = awvalid_q;
        awaddr_d     = awaddr_q;
        awlen_d      = awlen_q;
        next_addr_d  = next_addr_q;
        last_awlen_d = last_awlen_q;
        if (aw_hs) begin
            awvalid_d   = 1'b0;
            next_addr_d = next_addr_q + BURST_BYTES;
        end
        if (aw_issue) begin
            awvalid_d = 1'b1;
            awaddr_d  = next_addr_q;
            awlen_d   = aw_left_last ? last_awlen_q : 8'(C_BURST_LEN - 1);
        end
        if (start_ok) begin
            next_addr_d  = ctrl_addr_offset;
            last_awlen_d = (rem_in == '0) ? 8'(C_BURST_LEN - 1) : (8'(rem_in) - 8'd1);
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        w_credit_d    = w_credit_q;
        w_beat_d      = w_beat_q;
        if (start_ok) begin
            outstanding_d = '0;
            w_credit_d    = '0;
            w_beat_d      = '0;
        end else begin
            if (aw_hs && !b_hs) outstanding_d = outstanding_q + OW'(1);
            if (!aw_hs && b_hs) outstanding_d = outstanding_q - OW'(1);
            w_credit_d = w_credit_q + OW'(aw_hs) - OW'(w_hs && wlast);
            if (w_hs) w_beat_d = wlast ? '0 : (w_beat_q + BL_LOG2'(1));
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q       <= ST_IDLE;
            ctrl_done_q   <= 1'b0;
            bready_q      <= 1'b0;
            awvalid_q     <= 1'b0;
            awaddr_q      <= '0;
            awlen_q       <= '0;
            next_addr_q   <= '0;
            last_awlen_q  <= '0;
            outstanding_q <= '0;
            w_credit_q    <= '0;
            w_beat_q      <= '0;
        end else begin
            state_q       <= state_d;
            ctrl_done_q   <= ctrl_done_d;
            bready_q      <= 1'b1;
            awvalid_q     <= awvalid_d;
            awaddr_q      <= awaddr_d;
            awlen_q       <= awlen_d;
            next_addr_q   <= next_addr_d;
            last_awlen_q  <= last_awlen_d;
            outstanding_q <= outstanding_d;
            w_credit_q    <= w_credit_d;
            w_beat_q      <= w_beat_d;
        end
    end

    assign ctrl_done     = ctrl_done_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_wvalid  = s_axis_tvalid && w_ok;
    assign s_axis_tready = m_axi_wready && w_ok;
    assign m_axi_wdata   = s_axis_tdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = wlast;
    assign m_axi_bready  = bready_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_gactx_bank3_axis_wr_master.sv
// Directed bench for the bank-3 stream write master with an AXI slave model and stream source.
module tb_gactx_bank3_axis_wr_master;
    import gactx_bank3_pkg::*;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int XW = 32;

    logic            aclk = 1'b0;
    logic            areset_n = 1'b0;
    logic            ctrl_start = 1'b0;
    logic            ctrl_done;
    logic [AW-1:0]   ctrl_addr_offset = '0;
    logic [XW-1:0]   ctrl_xfer_size_in_bytes = '0;
    logic            awvalid, awready = 1'b0;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic            wvalid, wready = 1'b0;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            bvalid = 1'b0, bready;
    logic            tvalid = 1'b0, tready;
    logic [DW-1:0]   tdata = '0;
    wr_state_e       dbg_state;

    always #5 aclk = ~aclk;

    gactx_bank3_axis_wr_master dut (
        .aclk(aclk), .areset_n(areset_n),
        .ctrl_start(ctrl_start), .ctrl_done(ctrl_done),
        .ctrl_addr_offset(ctrl_addr_offset), .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wlast(wlast), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tdata(tdata),
        .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Test control, written only by the main initial block.
    int  sb_gen = 0;
    int  xfer_beats = 0;
    bit  rand_ready = 0;
    bit  rand_src = 0;
    bit  b_en = 1;
    int  start_cyc = 0;

    // Monitor / scoreboard state, written only by the monitor.
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] aw_addr_log[$];
    logic [7:0]    aw_len_log[$];
    int  mon_gen = 0;
    int  aw_cnt, b_cnt, w_beats, w_bursts, w_in_burst, done_cnt, b_pend, max_out;
    int  order_err, data_err, last_err, extra_err, stable_err;
    int  last_b_cyc, done_cyc;
    bit  aw_hs_f, w_hs_f, s_hs_f, b_hs_f;
    bit  aw_wait;
    logic [AW-1:0] aw_hold_addr;
    logic [7:0]    aw_hold_len;

    // Stream source state, written only by the source process.
    int src_gen = 0;
    int src_idx = 0;
    int src_left = 0;

    function automatic logic [DW-1:0] beat_data(input int idx);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++)
            d[i*32 +: 32] = (32'(idx) * 32'h0100_0193) ^ (32'(i) << 20) ^ 32'hC0DE_0000;
        return d;
    endfunction

    always @(posedge aclk) cyc <= cyc + 1;

    // Monitor samples on the falling edge, between the drivers and the next active edge.
    always @(negedge aclk) begin
        aw_hs_f = awvalid & awready;
        w_hs_f  = wvalid & wready;
        s_hs_f  = tvalid & tready;
        b_hs_f  = bvalid & bready;
        if (mon_gen != sb_gen) begin
            mon_gen = sb_gen;
            exp_q.delete(); aw_addr_log.delete(); aw_len_log.delete();
            for (int i = 0; i < xfer_beats; i++) exp_q.push_back(beat_data(i));
            aw_cnt = 0; b_cnt = 0; w_beats = 0; w_bursts = 0; w_in_burst = 0;
            done_cnt = 0; b_pend = 0; max_out = 0; order_err = 0; data_err = 0;
            last_err = 0; extra_err = 0; stable_err = 0; aw_wait = 0;
            last_b_cyc = -100; done_cyc = -100;
        end
        if (areset_n) begin
            if (aw_wait && (!awvalid || awaddr !== aw_hold_addr || awlen !== aw_hold_len))
                stable_err++;
            aw_wait = awvalid && !awready;
            aw_hold_addr = awaddr;
            aw_hold_len = awlen;
            if (w_hs_f) begin
                logic exp_last;
                if (w_bursts >= aw_cnt) order_err++;
                if (exp_q.size() == 0) extra_err++;
                else if (wdata !== exp_q.pop_front()) data_err++;
                exp_last = (w_bursts < aw_cnt) && (w_in_burst == int'(aw_len_log[w_bursts]));
                if (wlast !== exp_last) last_err++;
                w_beats++;
                if (wlast) begin w_bursts++; w_in_burst = 0; b_pend++; end
                else w_in_burst++;
            end
            if (aw_hs_f) begin
                aw_cnt++;
                aw_addr_log.push_back(awaddr);
                aw_len_log.push_back(awlen);
            end
            if (b_hs_f) begin b_cnt++; b_pend--; last_b_cyc = cyc; end
            if (aw_cnt - b_cnt > max_out) max_out = aw_cnt - b_cnt;
            if (ctrl_done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    // AXI slave model.
    initial forever begin
        @(posedge aclk); #1;
        if (!areset_n) begin
            awready = 0; wready = 0; bvalid = 0;
        end else begin
            awready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!(bvalid && !b_hs_f))
                bvalid = b_en && (b_pend > 0) && (!rand_ready || 1'($urandom_range(0, 1)));
        end
    end

    // Stream source; tvalid is held until accepted.
    initial forever begin
        @(posedge aclk); #1;
        if (src_gen != sb_gen) begin
            src_gen = sb_gen; src_idx = 0; src_left = xfer_beats; tvalid = 0;
        end else if (s_hs_f) begin
            src_idx++; src_left--;
        end
        if (!areset_n) tvalid = 0;
        else if (!(tvalid && !s_hs_f))
            tvalid = (src_left > 0) && (!rand_src || 1'($urandom_range(0, 1)));
        tdata = beat_data(src_idx);
    end

    task automatic start_xfer(input logic [AW-1:0] off, input int size);
        @(posedge aclk); #2;
        xfer_beats = size / 64;
        sb_gen++;
        ctrl_addr_offset = off;
        ctrl_xfer_size_in_bytes = 32'(size);
        ctrl_start = 1;
        start_cyc = cyc;
        @(posedge aclk); #2;
        ctrl_start = 0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge aclk);
            if (done_cnt > 0) begin ok = 1; break; end
        end
        repeat (4) @(posedge aclk);
        #2;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_done_timeout got done_cnt=%0d exp 1 within %0d cycles", name, done_cnt, budget);
        end
    endtask

    task automatic check_stream(input string name, input int beats, input int bursts);
        checks++;
        if (w_beats !== beats) begin errors++; $display("FAIL %s_beats got %0d exp %0d", name, w_beats, beats); end
        checks++;
        if (aw_cnt !== bursts) begin errors++; $display("FAIL %s_aw_cnt got %0d exp %0d", name, aw_cnt, bursts); end
        checks++;
        if (data_err + extra_err + exp_q.size() !== 0) begin
            errors++;
            $display("FAIL %s_data got mismatches=%0d extra=%0d left=%0d exp 0", name, data_err, extra_err, exp_q.size());
        end
        checks++;
        if (order_err !== 0) begin errors++; $display("FAIL %s_w_before_aw got %0d exp 0", name, order_err); end
        checks++;
        if (last_err !== 0) begin errors++; $display("FAIL %s_wlast got %0d errors exp 0", name, last_err); end
        checks++;
        if (stable_err !== 0) begin errors++; $display("FAIL %s_aw_stable got %0d errors exp 0", name, stable_err); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL %s_done_pulses got %0d exp 1", name, done_cnt); end
    endtask

    task automatic check_aw(input string name, input logic [AW-1:0] off, input int bursts, input int last_len);
        for (int k = 0; k < bursts; k++) begin
            logic [AW-1:0] ea;
            logic [7:0]    el;
            ea = off + 64'(k) * 64'h1000;
            el = (k == bursts - 1) ? 8'(last_len) : 8'd63;
            checks++;
            if (aw_addr_log[k] !== ea || aw_len_log[k] !== el) begin
                errors++;
                $display("FAIL %s_aw%0d got addr=%h len=%0d exp addr=%h len=%0d", name, k, aw_addr_log[k], aw_len_log[k], ea, el);
            end
        end
    endtask

    task automatic test_reset();
        areset_n = 0;
        repeat (3) @(posedge aclk);
        #2;
        checks++;
        if ({awvalid, wvalid, tready, ctrl_done, bready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 00000", {awvalid, wvalid, tready, ctrl_done, bready});
        end
        areset_n = 1;
        repeat (2) @(posedge aclk);
        #2;
        checks++;
        if (bready !== 1'b1 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_release got bready=%b state=%0d exp bready=1 state=0", bready, dbg_state);
        end
    endtask

    task automatic test_single();
        rand_ready = 0; rand_src = 0; b_en = 1;
        start_xfer(64'h1000, 4096);
        wait_done(1000, "single");
        check_stream("single", 64, 1);
        check_aw("single", 64'h1000, 1, 63);
        checks++;
        if (done_cyc - last_b_cyc !== 2) begin
            errors++;
            $display("FAIL single_done_after_b got %0d exp 2 samples", done_cyc - last_b_cyc);
        end
    endtask

    task automatic test_multi();
        logic [AW-1:0] off = 64'h0000_0002_0000_0000;
        rand_ready = 0; rand_src = 0; b_en = 1;
        start_xfer(off, 9 * 4096 + 128);
        repeat (20) @(posedge aclk);
        #2;
        ctrl_xfer_size_in_bytes = '0;
        ctrl_start = 1;
        @(posedge aclk); #2;
        ctrl_start = 0;
        wait_done(3000, "multi");
        check_stream("multi", 578, 10);
        check_aw("multi", off, 10, 1);
    endtask

    task automatic test_zero();
        start_xfer(64'h5000, 0);
        wait_done(50, "zero");
        checks++;
        if (aw_cnt !== 0 || w_beats !== 0) begin
            errors++;
            $display("FAIL zero_traffic got aw=%0d w=%0d exp 0 0", aw_cnt, w_beats);
        end
        checks++;
        if (done_cyc - start_cyc !== 2 || done_cnt !== 1) begin
            errors++;
            $display("FAIL zero_done got delay=%0d pulses=%0d exp 2 1", done_cyc - start_cyc, done_cnt);
        end
    endtask

    task automatic test_outstanding();
        bit ok = 0;
        rand_ready = 0; rand_src = 0; b_en = 0;
        start_xfer(64'h10_0000, 20 * 4096);
        for (int i = 0; i < 3000; i++) begin
            @(posedge aclk);
            if (w_beats >= 1024) begin ok = 1; break; end
        end
        repeat (50) @(posedge aclk);
        #2;
        checks++;
        if (!ok || aw_cnt !== 16 || awvalid !== 1'b0) begin
            errors++;
            $display("FAIL outst_stall got aw=%0d awvalid=%b exp 16 0", aw_cnt, awvalid);
        end
        checks++;
        if (w_beats !== 1024) begin errors++; $display("FAIL outst_w_continue got %0d exp 1024", w_beats); end
        b_en = 1;
        wait_done(4000, "outst");
        check_stream("outst", 1280, 20);
        checks++;
        if (max_out !== 16 || b_cnt !== 20) begin
            errors++;
            $display("FAIL outst_counts got max=%0d b=%0d exp 16 20", max_out, b_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] off = 64'hFFFF_FFFF_FFFF_E000;
        rand_ready = 1; rand_src = 1; b_en = 1;
        start_xfer(off, 3 * 4096 + 640);
        wait_done(4000, "bp");
        check_stream("bp", 202, 4);
        check_aw("bp", off, 4, 9);
        rand_ready = 0; rand_src = 0;
    endtask

    task automatic test_reset_mid();
        bit ok = 0;
        rand_ready = 0; rand_src = 0; b_en = 1;
        start_xfer(64'h4_0000, 4 * 4096);
        for (int i = 0; i < 500; i++) begin
            @(posedge aclk);
            if (w_beats >= 30) begin ok = 1; break; end
        end
        #2;
        checks++;
        if (!ok || wvalid !== 1'b1) begin errors++; $display("FAIL rstmid_active got beats=%0d wvalid=%b exp >=30 1", w_beats, wvalid); end
        areset_n = 0;
        xfer_beats = 0;
        sb_gen++;
        #1;
        checks++;
        if ({awvalid, wvalid, tready, ctrl_done} !== 4'b0) begin
            errors++;
            $display("FAIL rstmid_drop got %b exp 0000", {awvalid, wvalid, tready, ctrl_done});
        end
        repeat (3) @(posedge aclk);
        #2;
        areset_n = 1;
        repeat (10) @(posedge aclk);
        #2;
        checks++;
        if (dbg_state !== ST_IDLE || done_cnt !== 0) begin
            errors++;
            $display("FAIL rstmid_idle got state=%0d done=%0d exp 0 0", dbg_state, done_cnt);
        end
        start_xfer(64'h8000, 8192);
        wait_done(1000, "rstmid");
        check_stream("rstmid", 128, 2);
        check_aw("rstmid", 64'h8000, 2, 63);
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_zero();
        test_outstanding();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
